// File: rtl/pattern_match_ctrl.sv
// Serial bit-pattern detector with IDLE/RUN/DONE run control and a hit counter.
// match is registered one cycle after the completing bit; a run ends on max hits or abort.
module pattern_match_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] cfg_pattern,
  input  logic [2:0] cfg_len,
  input  logic       cfg_overlap,
  input  logic [7:0] cfg_max_hits,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       busy,
  output logic       done,
  output logic       match,
  output logic [7:0] hit_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] pat_q, max_q;
  logic [2:0] len_q;
  logic       ovl_q;
  logic [7:0] sh;
  logic [3:0] hist;

  logic       accept, hit, last_hit;
  logic [7:0] win, mask;
  logic [3:0] hist_inc, len_p1;

  // abort wins over a bit presented in the same cycle
  assign accept   = (state == RUN) && in_valid && !abort;
  assign win      = {sh[6:0], in_bit};
  assign mask     = 8'hFF >> (3'd7 - len_q);
  assign hist_inc = (hist == 4'd8) ? 4'd8 : hist + 4'd1;
  assign len_p1   = {1'b0, len_q} + 4'd1;
  assign hit      = accept && (((win ^ pat_q) & mask) == 8'h00) && (hist_inc >= len_p1);
  assign last_hit = hit && (max_q != 8'd0) && ((hit_count + 8'd1) == max_q);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (abort)         state_nxt = IDLE;
        else if (last_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q     <= 8'h00;
      max_q     <= 8'h00;
      len_q     <= 3'd0;
      ovl_q     <= 1'b0;
      sh        <= 8'h00;
      hist      <= 4'd0;
      hit_count <= 8'h00;
      match     <= 1'b0;
    end else begin
      match <= hit;
      if (state == IDLE && start) begin
        pat_q     <= cfg_pattern;
        max_q     <= cfg_max_hits;
        len_q     <= cfg_len;
        ovl_q     <= cfg_overlap;
        sh        <= 8'h00;
        hist      <= 4'd0;
        hit_count <= 8'h00;
      end else if (accept) begin
        sh <= win;
        // non-overlapping mode forgets every bit of the matched pattern
        hist <= (hit && !ovl_q) ? 4'd0 : hist_inc;
        if (hit && hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_match_ctrl.sv
// Scoreboard bench: stimulus queues expected match events, a negedge monitor pops and compares.
module tb_pattern_match_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] cfg_pattern = 8'h00;
  logic [2:0] cfg_len = 3'd0;
  logic       cfg_overlap = 1'b0;
  logic [7:0] cfg_max_hits = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       busy, done, match;
  logic [7:0] hit_count;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [7:0] hits;
    logic       dn;
  } exp_t;
  exp_t q[$];

  pattern_match_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_max_hits(cfg_max_hits), .in_valid(in_valid), .in_bit(in_bit),
    .busy(busy), .done(done), .match(match), .hit_count(hit_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Monitor: every match pulse must correspond to the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (match) begin
        if (q.size() == 0) chk("unexpected_match", int'(match), 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("match_cycle", cyc, e.cyc);
          chk("match_hits", int'(hit_count), int'(e.hits));
          chk("match_done", int'(done), int'(e.dn));
        end
      end else if (done) begin
        chk("unexpected_done", int'(done), 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [7:0] p, input logic [2:0] l, input logic o, input logic [7:0] m);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_max_hits = m;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("hits_cleared", int'(hit_count), 0);
    // latched copies must be used from here on
    cfg_pattern = ~p; cfg_len = l + 3'd2; cfg_overlap = ~o; cfg_max_hits = 8'd1;
  endtask

  task automatic send(input logic b, input logic em, input logic [7:0] eh, input logic ed);
    exp_t e;
    in_valid = 1'b1;
    in_bit   = b;
    if (em) begin
      e.cyc = cyc + 1; e.hits = eh; e.dn = ed;
      q.push_back(e);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic stream_1101101(input logic ovl, input logic [7:0] maxh);
    send(1, 0, 0, 0);
    send(1, 0, 0, 0);
    send(0, 0, 0, 0);
    send(1, 1, 1, 0);
    send(1, 0, 0, 0);
    send(0, 0, 0, 0);
    send(1, ovl, 2, (maxh == 8'd2));
  endtask

  initial begin
    // reset
    step(); step();
    reset = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_match", int'(match), 0);
    chk("rst_hits", int'(hit_count), 0);

    // overlapping detection
    start_run(8'h0D, 3'd3, 1'b1, 8'd0);
    stream_1101101(1'b1, 8'd0);
    step();
    do_abort();
    chk("ovl_busy_after_abort", int'(busy), 0);
    chk("ovl_hits", int'(hit_count), 2);
    step();
    chk("ovl_hits_hold_idle", int'(hit_count), 2);

    // non-overlapping detection
    start_run(8'h0D, 3'd3, 1'b0, 8'd0);
    stream_1101101(1'b0, 8'd0);
    step();
    do_abort();
    chk("novl_hits", int'(hit_count), 1);

    // completion at max_hits
    start_run(8'h0D, 3'd3, 1'b1, 8'd2);
    stream_1101101(1'b1, 8'd2);
    chk("cmp_done_high", int'(done), 1);
    chk("cmp_busy_low", int'(busy), 0);
    step();
    chk("cmp_done_one_cycle", int'(done), 0);
    chk("cmp_idle_busy", int'(busy), 0);
    chk("cmp_hits_hold", int'(hit_count), 2);

    // single-bit pattern with gaps
    start_run(8'h01, 3'd0, 1'b0, 8'd0);
    send(1, 1, 1, 0);
    step();
    send(0, 0, 0, 0);
    step();
    send(1, 1, 2, 0);
    step();
    do_abort();
    chk("gap_hits", int'(hit_count), 2);

    // reset mid-pattern discards history
    start_run(8'h0D, 3'd3, 1'b1, 8'd0);
    send(1, 0, 0, 0);
    send(1, 0, 0, 0);
    send(0, 0, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_hits", int'(hit_count), 0);
    start_run(8'h0D, 3'd3, 1'b1, 8'd0);
    send(1, 0, 0, 0);
    step(); step();
    do_abort();
    chk("midrst_no_match_hits", int'(hit_count), 0);

    // abort coincident with the completing bit
    start_run(8'h0D, 3'd3, 1'b1, 8'd2);
    send(1, 0, 0, 0);
    send(1, 0, 0, 0);
    send(0, 0, 0, 0);
    abort = 1'b1;
    send(1, 0, 0, 0);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_hits", int'(hit_count), 0);
    step(); step();

    // hit_count saturation in unlimited mode
    start_run(8'h01, 3'd0, 1'b1, 8'd0);
    for (int i = 1; i <= 260; i++) send(1, 1, (i > 255) ? 8'd255 : 8'(i), 0);
    step();
    do_abort();
    chk("sat_hits", int'(hit_count), 255);

    step(); step();
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pattern_match_ctrl.md
PATTERN_MATCH_CTRL -- requirements
Module: pattern_match_ctrl

Interface
REQ-001: Parameters: none; the pattern window is fixed at 8 bits and the hit counter at 8 bits.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004: start  input  1  begin a detection run; honoured only in IDLE.
REQ-005: abort  input  1  terminate a run; honoured only in RUN.
REQ-006: cfg_pattern  input  8  target pattern; bit [cfg_len] is received first and bit [0] is received last.
REQ-007: cfg_len  input  3  pattern length minus one (1..8 bits).
REQ-008: cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-009: cfg_max_hits  input  8  run ends after this many matches; 0 = unlimited.
REQ-010: in_valid  input  1  in_bit qualifier.
REQ-011: in_bit  input  1  serial data bit.
REQ-012: busy  output  1  high while in RUN.
REQ-013: done  output  1  one-cycle pulse on normal run completion.
REQ-014: match  output  1  registered one-cycle pulse per detected pattern.
REQ-015: hit_count  output  8  matches counted in the current or last run.

Function
REQ-016: The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017: In IDLE, start=1 SHALL latch all cfg_* inputs, clear hit_count, clear the history count and shift register, and enter RUN on the next edge.
REQ-018: cfg_* changes during RUN or DONE SHALL have no effect; only the latched copies are used.
REQ-019: A bit SHALL be accepted only when state=RUN and in_valid=1; in_valid SHALL be ignored in IDLE and DONE.
REQ-020: On each accepted bit:
- shift register <= {sh[6:0], in_bit};
- history count increments, saturating at 8.
REQ-021: A match SHALL occur on an accepted bit when:
- the new window {sh[6:0], in_bit} masked to L = cfg_len+1 LSBs equals cfg_pattern masked to L LSBs, and
- the history count including this bit is >= L.
REQ-022: match SHALL be 1 in the cycle after the edge that accepts the completing bit (latency 1), and 0 otherwise.
REQ-023: On a match, hit_count SHALL increment at the same edge that sets match.
REQ-024: On a match with cfg_overlap=0, the history count SHALL reset to 0 so that no bit of the matched pattern participates in a later match.
REQ-025: On a match with cfg_overlap=1, the history count SHALL be retained.
REQ-026: If cfg_max_hits!=0 and a match makes hit_count equal cfg_max_hits, the FSM SHALL enter DONE at that edge.
- done and the final match pulse are therefore high in the same cycle.
REQ-027: DONE SHALL last exactly one cycle, then return to IDLE.
- done = (state==DONE); busy = (state==RUN).
REQ-028: If cfg_max_hits=0, hit_count SHALL saturate at 255 and the run SHALL continue until abort.
REQ-029: abort=1 in RUN SHALL return to IDLE on the next edge without asserting done.
- abort SHALL take priority over a bit accepted in the same cycle: no match, and hit_count is unchanged.
REQ-030: start asserted in RUN or DONE SHALL be ignored; abort asserted in IDLE or DONE SHALL be ignored.
REQ-031: hit_count SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-032: reset=1 SHALL, at the next edge and regardless of state, force:
- state=IDLE;
- busy=0, done=0, match=0, hit_count=0;
- shift register and history count cleared.
REQ-033: reset SHALL take priority over start, abort and in_valid in the same cycle.
REQ-034: Reset mid-run SHALL discard all partial history; a pattern straddling the reset SHALL NOT match.

Verification
REQ-035: Overlap test. Configure pattern=0x0D, len=3, overlap=1, max_hits=0, then stream 1,1,0,1,1,0,1 with in_valid continuous.
- match pulses after the 4th bit and after the 7th bit; hit_count=2.
REQ-036: Non-overlap test. Same configuration and stream as REQ-035 with overlap=0.
- match pulses after the 4th bit only; hit_count=1.
REQ-037: Completion test. max_hits=2 with the REQ-035 configuration and stream.
- done and match are both high in the cycle after the 7th bit;
- busy drops in that same cycle; IDLE follows in the next cycle; hit_count holds at 2.
REQ-038: Gap test. len=0, pattern=0x01, stream 1,0,1 with in_valid=0 gaps between bits.
- exactly 2 match pulses, and no pulse in any gap cycle.
REQ-039: Reset/abort test. Apply reset after bits 1,1,0 of 1101, then start again and send only 1.
- no match.
- Separately, abort in the same cycle as the completing bit gives no match, hit_count unchanged and no done.
